// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two 8N1 UART bytes, high byte first.
// Bits are held for BAUD_DIV clocks. The start bit begins one clock after the
// request is accepted. busy falls and cmd_snt rises on the edge that ends the
// low byte's stop bit.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TX_HIGH = 2'd1, TX_LOW = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;   // 0 start, 1..8 data, 9 stop
  logic          lead;      // the single clock between capture and the start bit
  logic [15:0]   hold;
  logic          accept, bit_end, byte_end;
  logic [7:0]    cur_byte;

  assign accept   = (state == IDLE) && snd_cmd;
  assign bit_end  = !lead && (baud_cnt == BAUD_LAST);
  assign byte_end = bit_end && (bit_cnt == 4'd9);
  assign cur_byte = (state == TX_LOW) ? hold[7:0] : hold[15:8];

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // next-state logic: each byte ends when its stop bit has run its full time
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snd_cmd)  state_nxt = TX_HIGH;
      TX_HIGH: if (byte_end) state_nxt = TX_LOW;
      TX_LOW:  if (byte_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy is decoded from the state
  always_comb busy = (state != IDLE);

  // holding register: loaded only on an accepted request, so later cmd changes are ignored
  always_ff @(posedge clk)
    if (accept) hold <= cmd;

  // baud/bit counters, registered serial line and the sticky completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      lead     <= 1'b0;
      TX       <= 1'b1;
      cmd_snt  <= 1'b0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      TX       <= 1'b1;
      lead     <= snd_cmd;
      if (snd_cmd) cmd_snt <= 1'b0;
    end else if (lead) begin
      lead <= 1'b0;
      TX   <= 1'b0;                       // start bit of the high byte
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        bit_cnt <= '0;
        // The high byte's stop bit leads straight into the low byte's start bit.
        TX <= (state == TX_HIGH) ? 1'b0 : 1'b1;
        if (state == TX_LOW) cmd_snt <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        TX      <= (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
      end
    end
  end
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: drives remote_comm with directed and random commands. A
// behavioural UART receiver decodes TX into bytes and reassembled commands.
// Each result is compared with the command that was sent.
module tb_remote_comm;
  localparam int D = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        tx, busy, cmd_snt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int snt_cyc  = 0;

  // receiver model state
  logic [7:0]  bq[$];
  logic [7:0]  m_b, m_hi;
  logic        m_st, m_sp;
  bit          have_hi = 1'b0;
  bit          rx_rdy  = 1'b0;
  logic [15:0] rx_cmd  = '0;
  int          rx_rdy_cyc = 0;

  // results of the last wait_done
  int fl, ln, sa, sr;

  remote_comm #(.BAUD_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd),
    .TX(tx), .busy(busy), .cmd_snt(cmd_snt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver: sample mid-bit, keep only well-framed bytes, pair them high then low
  initial begin : monitor
    forever begin
      @(negedge tx);
      repeat (D/2) @(negedge clk);
      m_st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (D) @(negedge clk);
        m_b[i] = tx;
      end
      repeat (D) @(negedge clk);
      m_sp = tx;
      if (m_st == 1'b0 && m_sp == 1'b1) begin
        bq.push_back(m_b);
        if (!have_hi) begin
          m_hi = m_b; have_hi = 1'b1;
        end else begin
          rx_cmd = {m_hi, m_b}; rx_rdy = 1'b1; rx_rdy_cyc = cyc; have_hi = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic clear_mon();
    bq.delete();
    have_hi = 1'b0;
    rx_rdy  = 1'b0;
  endtask

  // one-cycle request, called at a falling clock edge
  task automatic issue(input logic [15:0] c);
    cmd = c; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  // waits for the start bit, then for busy to drop; optionally pokes cmd/snd_cmd at cycle poke_at
  task automatic wait_done(input int poke_at, input logic [15:0] poke_cmd, input logic poke_snd);
    logic prev;
    fl = 0;
    while (tx !== 1'b0 && fl < 4) begin @(negedge clk); fl++; end
    ln = 0; sa = -1; sr = 0; prev = cmd_snt;
    while (ln < 25*D) begin
      if (ln == poke_at) begin cmd = poke_cmd; snd_cmd = poke_snd; end
      @(negedge clk);
      ln++;
      snd_cmd = 1'b0;
      if (cmd_snt === 1'b1 && prev !== 1'b1) begin
        sr++;
        if (sa < 0) begin sa = ln; snt_cyc = cyc; end
      end
      prev = cmd_snt;
      if (busy !== 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd = '0; snd_cmd = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cmd_snt !== 1'b0) begin failures++; $display("FAIL reset_snt: got %b want 0", cmd_snt); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: tx=%b busy=%b want 1 0", tx, busy); end
  endtask

  task automatic test_basic();
    logic [15:0] c, got;
    c = 16'hA53C;
    clear_mon();
    issue(c);
    checks++; if (busy !== 1'b1 || tx !== 1'b1 || cmd_snt !== 1'b0) begin failures++; $display("FAIL accept_state: busy=%b tx=%b snt=%b want 1 1 0", busy, tx, cmd_snt); end
    wait_done(-1, '0, 1'b0);
    checks++; if (fl !== 1) begin failures++; $display("FAIL start_latency: got %0d want 1", fl); end
    checks++; if (ln !== 20*D) begin failures++; $display("FAIL frame_len: got %0d want %0d", ln, 20*D); end
    checks++; if (sa !== 20*D) begin failures++; $display("FAIL snt_time: got %0d want %0d", sa, 20*D); end
    got = (bq.size() >= 2) ? {bq[0], bq[1]} : 16'hxxxx;
    checks++; if (bq.size() !== 2 || got !== c) begin failures++; $display("FAIL basic_bytes: got %h (%0d bytes) want %h", got, bq.size(), c); end
  endtask

  task automatic test_loopback();
    clear_mon();
    repeat (2) @(negedge clk);
    issue(16'h0003);
    wait_done(-1, '0, 1'b0);
    checks++; if (rx_rdy !== 1'b1 || rx_cmd !== 16'h0003) begin failures++; $display("FAIL loopback_cmd: got %h rdy=%b want 0003 rdy=1", rx_cmd, rx_rdy); end
    checks++; if (!(rx_rdy_cyc < snt_cyc)) begin failures++; $display("FAIL loopback_order: rdy at %0d snt at %0d want rdy first", rx_rdy_cyc, snt_cyc); end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] got;
    clear_mon();
    issue(16'h5AC3);
    wait_done(5*D, 16'hFFFF, 1'b1);
    got = (bq.size() >= 2) ? {bq[0], bq[1]} : 16'hxxxx;
    checks++; if (got !== 16'h5AC3) begin failures++; $display("FAIL ignore_bytes: got %h want 5ac3", got); end
    checks++; if (ln !== 20*D) begin failures++; $display("FAIL ignore_busy_len: got %0d want %0d", ln, 20*D); end
    checks++; if (sr !== 1) begin failures++; $display("FAIL ignore_snt_rises: got %0d want 1", sr); end
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("FAIL ignore_no_restart: busy=%b tx=%b want 0 1", busy, tx); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    int bad;
    clear_mon();
    issue(16'hC0DE);
    repeat (15*D) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before_reset: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || cmd_snt !== 1'b0) begin failures++; $display("FAIL async_reset: tx=%b busy=%b snt=%b want 1 0 0", tx, busy, cmd_snt); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12*D) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) bad++; end
    checks++; if (bad !== 0) begin failures++; $display("FAIL post_reset_idle: got %0d non-idle cycles want 0", bad); end
    clear_mon();
    issue(16'h1234);
    wait_done(-1, '0, 1'b0);
    got = (bq.size() >= 2) ? {bq[0], bq[1]} : 16'hxxxx;
    checks++; if (got !== 16'h1234 || ln !== 20*D) begin failures++; $display("FAIL after_reset_frame: got %h len %0d want 1234 len %0d", got, ln, 20*D); end
  endtask

  task automatic test_cmd_change();
    logic [15:0] got;
    clear_mon();
    issue(16'h8001);
    cmd = 16'h0000;
    wait_done(-1, '0, 1'b0);
    got = (bq.size() >= 2) ? {bq[0], bq[1]} : 16'hxxxx;
    checks++; if (got !== 16'h8001) begin failures++; $display("FAIL cmd_change: got %h want 8001", got); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    clear_mon();
    issue(16'h00FF);
    wait_done(-1, '0, 1'b0);
    checks++; if (cmd_snt !== 1'b1) begin failures++; $display("FAIL b2b_first_snt: got %b want 1", cmd_snt); end
    issue(16'hFF00);
    checks++; if (cmd_snt !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: snt=%b busy=%b want 0 1", cmd_snt, busy); end
    wait_done(-1, '0, 1'b0);
    checks++; if (cmd_snt !== 1'b1 || ln !== 20*D) begin failures++; $display("FAIL b2b_second_done: snt=%b len=%0d want 1 %0d", cmd_snt, ln, 20*D); end
    got = (bq.size() >= 4) ? {bq[0], bq[1], bq[2], bq[3]} : 32'hxxxxxxxx;
    checks++; if (bq.size() !== 4 || got !== 32'h00FF_FF00) begin failures++; $display("FAIL b2b_bytes: got %h want 00ffff00", got); end
  endtask

  task automatic test_coincident();
    logic [15:0] c;
    c = 16'($urandom_range(0, 65535));
    clear_mon();
    issue(c);
    wait_done(20*D - 1, ~c, 1'b1);
    checks++; if (ln !== 20*D) begin failures++; $display("FAIL coincident_len: got %0d want %0d", ln, 20*D); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx !== 1'b1 || cmd_snt !== 1'b1) begin failures++; $display("FAIL coincident_dropped: busy=%b tx=%b snt=%b want 0 1 1", busy, tx, cmd_snt); end
  endtask

  task automatic test_random();
    logic [15:0] c, got;
    for (int k = 0; k < 5; k++) begin
      c = 16'($urandom_range(0, 65535));
      clear_mon();
      repeat ($urandom_range(1, 5)) @(negedge clk);
      issue(c);
      if (k[0]) cmd = 16'($urandom_range(0, 65535));
      wait_done(-1, '0, 1'b0);
      got = (bq.size() >= 2) ? {bq[0], bq[1]} : 16'hxxxx;
      checks++; if (got !== c || rx_cmd !== c) begin failures++; $display("FAIL random_%0d: bytes %h rx %h want %h", k, got, rx_cmd, c); end
      checks++; if (ln !== 20*D || sa !== 20*D) begin failures++; $display("FAIL random_len_%0d: len %0d snt %0d want %0d", k, ln, sa, 20*D); end
    end
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_loopback();
    test_busy_ignore();
    test_reset_mid();
    test_cmd_change();
    test_back_to_back();
    test_coincident();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, giving clocks per UART bit time (19200 baud at 50 MHz).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cmd, input, 16, command word to transmit; sampled only when a send is accepted.
REQ-005 SHALL have port snd_cmd, input, 1, single-cycle request to transmit cmd.
REQ-006 SHALL have port TX, output, 1, UART serial line, idle high.
REQ-007 SHALL have port busy, output, 1, high while a command frame is in progress.
REQ-008 SHALL have port cmd_snt, output, 1, sticky flag: last accepted command fully transmitted.

Function
REQ-009 SHALL send each command as two 8N1 UART bytes: high byte cmd[15:8] first, then low byte cmd[7:0], so the existing UART command receiver reassembles cmd unchanged.
REQ-010 SHALL frame each byte as start bit (0), data bits LSB first, stop bit (1); each bit held on TX for exactly BAUD_DIV clocks.
REQ-011 SHALL register TX (no combinational path from inputs to TX).
REQ-012 SHALL implement states IDLE, TX_HIGH, TX_LOW.
REQ-013 IDLE: snd_cmd=1 -> capture cmd into a 16-bit holding register, clear cmd_snt, assert busy, go to TX_HIGH.
REQ-014 TX_HIGH: shift out high byte; at the end of its stop bit go directly to TX_LOW with no idle gap.
REQ-015 TX_LOW: shift out low byte; at the end of its stop bit set cmd_snt, deassert busy, return to IDLE.
REQ-016 The start bit of the high byte SHALL begin on the clock edge following the edge on which snd_cmd is sampled high.
REQ-017 busy and cmd_snt SHALL change on the same edge TX_LOW's stop bit completes; total frame length is exactly 20*BAUD_DIV clocks from TX first falling to busy falling.
REQ-018 snd_cmd asserted while busy=1 SHALL be ignored: no re-capture, no restart, cmd_snt unaffected.
REQ-019 snd_cmd asserted on the same cycle busy falls (IDLE entered) SHALL be accepted on the next cycle it is seen high in IDLE only; a request coincident with completion is dropped.
REQ-020 Changes on cmd after capture SHALL NOT affect the frame in progress.
REQ-021 cmd_snt SHALL remain high until the next accepted snd_cmd clears it.
REQ-022 Baud counter SHALL be wide enough for BAUD_DIV-1 and reset to 0 at every bit boundary; bit counter counts 0..9 per byte (start, 8 data, stop).
REQ-023 TX SHALL be 1 whenever in IDLE.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, TX=1, busy=0, cmd_snt=0, baud and bit counters 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; after release TX stays 1 until a new snd_cmd.
REQ-026 Holding register contents need no reset value.

Verification
REQ-027 Bench SHALL cover: reset, then snd_cmd with cmd=16'hA53C -> TX bytes 0xA5 then 0x3C decoded, cmd_snt=1 exactly 20*BAUD_DIV clocks after first TX fall.
REQ-028 Bench SHALL cover: loopback into the team's UART command receiver with cmd=16'h0003 -> receiver cmd=16'h0003 and cmd_rdy=1 before cmd_snt rises.
REQ-029 Bench SHALL cover: snd_cmd pulsed again mid-frame with cmd=16'hFFFF -> frame still carries original value, busy continuous, single cmd_snt rise.
REQ-030 Bench SHALL cover: rst_n pulsed low during low byte -> TX=1, busy=0, cmd_snt=0 same cycle; next command 16'h1234 transmits correctly.
REQ-031 Bench SHALL cover: cmd changed to 16'h0000 one cycle after capture of 16'h8001 -> transmitted bytes 0x80, 0x01.
REQ-032 Bench SHALL cover: back-to-back commands 16'h00FF then 16'hFF00, second issued on first cycle after busy falls -> both decoded in order, cmd_snt clears and re-sets.
